// File: rtl/carryadder8_arbiter.sv
// Round-robin front end that shares one carryadder8 among NUM_REQ requesters.
// It takes one operand set at a time, walks the adder through its
// enable / write / strobe handshake, waits for the adder to run and go idle
// again, then returns a one-cycle result pulse to the requester it granted.
// A watchdog turns an adder that never starts or never finishes into an
// error response, so a requester is never left waiting.
module carryadder8_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_addend0,
  input  logic [8*NUM_REQ-1:0]   req_addend1,
  input  logic [NUM_REQ-1:0]     req_carry,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_sum,
  output logic                   rsp_carry,
  output logic                   rsp_zero,
  output logic                   rsp_error,
  output logic                   ca_enable,
  output logic                   ca_write,
  output logic                   ca_strobe,
  output logic                   ca_carryflag,
  output logic [7:0]             ca_addend0,
  output logic [7:0]             ca_addend1,
  input  logic [7:0]             ca_sum,
  input  logic                   ca_carry,
  input  logic                   ca_zero,
  input  logic                   ca_ready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ENABLE = 4'd1;
  localparam logic [3:0] ST_LOAD   = 4'd2;
  localparam logic [3:0] ST_CLEAR  = 4'd3;
  localparam logic [3:0] ST_STROBE = 4'd4;
  localparam logic [3:0] ST_START  = 4'd5;
  localparam logic [3:0] ST_RUN    = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;
  localparam logic [3:0] ST_ERR    = 4'd8;

  logic [3:0]         state_reg, state_next;
  logic               phase_reg, phase_next;   // second cycle of LOAD / CLEAR
  logic [CW-1:0]      wdog_reg, wdog_next;
  logic [IW-1:0]      ptr_reg;
  logic [IW-1:0]      gnt_reg;
  logic [7:0]         op_a_reg, op_b_reg;
  logic               op_c_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [7:0]         rsp_sum_reg;
  logic               rsp_carry_reg, rsp_zero_reg, rsp_error_reg;

  logic [7:0]         a_arr [NUM_REQ];
  logic [7:0]         b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               grant_found;
  logic [IW-1:0]      grant_idx;
  logic               grant_fire;
  logic               wdog_expired;

  // Unpack the flat operand buses and decode the held grant index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]      = req_addend0[8*gi +: 8];
      assign b_arr[gi]      = req_addend1[8*gi +: 8];
      assign gnt_onehot[gi] = (gnt_reg == IW'(gi));
      // Accept pulse is gated by reset so nothing is accepted while held in reset.
      assign req_ready[gi]  = grant_fire && (grant_idx == IW'(gi));
    end
  endgenerate

  // Round-robin search: start one past the last winner and wrap.
  always_comb begin
    int cand_int;
    logic [IW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_int    = 0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = (int'(ptr_reg) + k) % NUM_REQ;
      cand     = IW'(cand_int);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_fire   = aresetn && (state_reg == ST_IDLE) && grant_found;
  assign wdog_expired = (wdog_reg == CW'(TIMEOUT - 1));

  // Sequencer next state: fixed-length handshake phases, then adder-paced waits.
  always_comb begin
    state_next = state_reg;
    phase_next = 1'b0;
    wdog_next  = wdog_reg;
    case (state_reg)
      ST_IDLE:   if (grant_found) state_next = ST_ENABLE;
      ST_ENABLE: state_next = ST_LOAD;
      ST_LOAD: begin
        phase_next = ~phase_reg;
        if (phase_reg) begin
          state_next = ST_CLEAR;
          phase_next = 1'b0;
        end
      end
      ST_CLEAR: begin
        phase_next = ~phase_reg;
        if (phase_reg) begin
          state_next = ST_STROBE;
          phase_next = 1'b0;
        end
      end
      ST_STROBE: begin
        state_next = ST_START;
        wdog_next  = '0;
      end
      ST_START: begin
        wdog_next = wdog_reg + CW'(1);
        if (!ca_ready)         state_next = ST_RUN;
        else if (wdog_expired) state_next = ST_ERR;
      end
      ST_RUN: begin
        wdog_next = wdog_reg + CW'(1);
        if (ca_ready)          state_next = ST_DONE;
        else if (wdog_expired) state_next = ST_ERR;
      end
      ST_DONE:   state_next = ST_IDLE;
      ST_ERR:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping, operand capture and registered response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= 1'b0;
      wdog_reg      <= '0;
      ptr_reg       <= IW'(NUM_REQ - 1);
      gnt_reg       <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      op_c_reg      <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_sum_reg   <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      wdog_reg      <= wdog_next;
      rsp_valid_reg <= '0;
      if (state_reg == ST_IDLE && grant_found) begin
        gnt_reg  <= grant_idx;
        ptr_reg  <= grant_idx;
        op_a_reg <= a_arr[grant_idx];
        op_b_reg <= b_arr[grant_idx];
        op_c_reg <= req_carry[grant_idx];
      end
      if (state_reg == ST_DONE) begin
        rsp_valid_reg <= gnt_onehot;
        rsp_sum_reg   <= ca_sum;
        rsp_carry_reg <= ca_carry;
        rsp_zero_reg  <= ca_zero;
        rsp_error_reg <= 1'b0;
      end else if (state_reg == ST_ERR) begin
        rsp_valid_reg <= gnt_onehot;
        rsp_sum_reg   <= '0;
        rsp_carry_reg <= 1'b0;
        rsp_zero_reg  <= 1'b0;
        rsp_error_reg <= 1'b1;
      end
    end
  end

  assign ca_enable    = (state_reg != ST_IDLE);
  assign ca_write     = (state_reg == ST_LOAD);
  assign ca_strobe    = (state_reg == ST_STROBE);
  assign ca_addend0   = op_a_reg;
  assign ca_addend1   = op_b_reg;
  assign ca_carryflag = op_c_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_error = rsp_error_reg;

endmodule

// File: tb/tb_carryadder8_arbiter.sv
// Bench for carryadder8_arbiter: behavioural carryadder8 stand-in, grant
// watcher that predicts round-robin winners and queues expected results,
// and an independent response monitor that pops and compares.
module tb_carryadder8_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic                 aclk;
  logic                 aresetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_addend0;
  logic [8*NUM_REQ-1:0] req_addend1;
  logic [NUM_REQ-1:0]   req_carry;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_sum;
  logic                 rsp_carry, rsp_zero, rsp_error;
  logic                 ca_enable, ca_write, ca_strobe, ca_carryflag;
  logic [7:0]           ca_addend0, ca_addend1;
  logic [7:0]           ca_sum;
  logic                 ca_carry, ca_zero, ca_ready;

  carryadder8_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_addend0(req_addend0), .req_addend1(req_addend1),
    .req_carry(req_carry), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_error(rsp_error),
    .ca_enable(ca_enable), .ca_write(ca_write), .ca_strobe(ca_strobe),
    .ca_carryflag(ca_carryflag), .ca_addend0(ca_addend0), .ca_addend1(ca_addend1),
    .ca_sum(ca_sum), .ca_carry(ca_carry), .ca_zero(ca_zero), .ca_ready(ca_ready)
  );

  typedef struct {
    int         idx;
    logic [7:0] sum;
    logic       c;
    logic       z;
    logic       err;
    int         gcyc;
  } exp_t;

  exp_t               exp_q[$];
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 rr_last = NUM_REQ - 1;
  int                 last_gcyc = 0;
  int                 n_grants = 0;
  logic [NUM_REQ-1:0] granted_mask = '0;
  logic               hold_all = 1'b0;
  logic               stuck = 1'b0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration rule: first valid requester after the last winner.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_addend0[8*i +: 8] = a;
    req_addend1[8*i +: 8] = b;
    req_carry[i]          = c;
    req_valid[i]          = 1'b1;
  endtask

  task automatic issue_rand(input int i);
    issue(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic sync();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_idle(input int limit);
    logic done;
    done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      sync();
      if (exp_q.size() == 0 && req_valid == '0 && !ca_enable) done = 1'b1;
    end
    check("idle_wait", done, 1'b1);
  endtask

  // Behavioural carryadder8: latches operands while written, starts on strobe,
  // drops ready while running, then raises ready with the result.
  initial begin
    int ad_state, ad_cnt;
    logic [7:0] la, lb;
    logic lc;
    logic [8:0] s9;
    ca_ready = 1'b1; ca_sum = '0; ca_carry = 1'b0; ca_zero = 1'b0;
    ad_state = 0; ad_cnt = 0; la = '0; lb = '0; lc = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        ad_state = 0;
        ca_ready = 1'b1;
      end else begin
        case (ad_state)
          0: begin
            if (ca_write) begin la = ca_addend0; lb = ca_addend1; lc = ca_carryflag; end
            if (ca_strobe && !stuck) begin ad_cnt = $urandom_range(0, 2); ad_state = 1; end
          end
          1: if (ad_cnt == 0) begin
               ca_ready = 1'b0; ad_cnt = $urandom_range(1, 4); ad_state = 2;
             end else ad_cnt--;
          2: if (ad_cnt == 0) begin
               s9 = {1'b0, la} + {1'b0, lb} + {8'b0, lc};
               ca_sum = s9[7:0]; ca_carry = s9[8]; ca_zero = (s9[7:0] == 8'h00);
               ca_ready = 1'b1; ad_state = 0;
             end else ad_cnt--;
          default: ad_state = 0;
        endcase
      end
    end
  end

  // Requester side: a granted request is withdrawn (or refreshed when held).
  initial forever begin
    @(posedge aclk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (granted_mask[i]) begin
        if (hold_all) issue_rand(i);
        else req_valid[i] = 1'b0;
      end
    granted_mask = '0;
  end

  // Grant watcher and handshake shape checks; pushes expected responses.
  initial begin
    int win, w_run, s_run;
    logic [7:0] a, b;
    logic c;
    logic [8:0] s9;
    exp_t e;
    w_run = 0; s_run = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        w_run = 0; s_run = 0;
      end else begin
        if (ca_write) w_run++;
        else if (w_run != 0) begin check("ca_write_len", 64'(w_run), 64'd2); w_run = 0; end
        if (ca_strobe) begin
          if (s_run == 0) check("grant_to_strobe", 64'(cyc - last_gcyc), 64'd6);
          s_run++;
        end else if (s_run != 0) begin check("ca_strobe_len", 64'(s_run), 64'd1); s_run = 0; end
        if (req_ready != '0) begin
          win = rr_pick(req_valid, rr_last);
          check("ready_onehot", 64'($countones(req_ready)), 64'd1);
          check("grant_idx", 64'(req_ready), (win < 0) ? 64'd0 : (64'd1 << win));
          check("grant_while_busy", 64'(exp_q.size()), 64'd0);
          if (win >= 0) begin
            a  = req_addend0[8*win +: 8];
            b  = req_addend1[8*win +: 8];
            c  = req_carry[win];
            s9 = {1'b0, a} + {1'b0, b} + {8'b0, c};
            e.idx = win; e.gcyc = cyc; e.err = stuck;
            e.sum = stuck ? 8'h00 : s9[7:0];
            e.c   = stuck ? 1'b0 : s9[8];
            e.z   = stuck ? 1'b0 : (s9[7:0] == 8'h00);
            exp_q.push_back(e);
            rr_last = win;
          end
          granted_mask = granted_mask | req_ready;
          last_gcyc = cyc;
          n_grants++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every result pulse.
  initial begin
    exp_t e;
    logic [10:0] last_pl;
    int lat;
    last_pl = '0;
    forever begin
      sync();
      if (!aresetn) begin
        last_pl = '0;
      end else begin
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            lat = cyc - e.gcyc;
            check("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
            check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
            check("rsp_carry", 64'(rsp_carry), 64'(e.c));
            check("rsp_zero", 64'(rsp_zero), 64'(e.z));
            check("rsp_error", 64'(rsp_error), 64'(e.err));
            if (e.err) check("timeout_latency", 64'(lat), 64'(TIMEOUT + 8));
            else check("rsp_latency_range", 64'(lat >= 11 && lat <= 30), 64'd1);
            $display("rsp req=%0d sum=%02h carry=%0d zero=%0d err=%0d lat=%0d",
                     e.idx, rsp_sum, rsp_carry, rsp_zero, rsp_error, lat);
          end
        end else begin
          check("rsp_hold", 64'({rsp_sum, rsp_carry, rsp_zero, rsp_error}), 64'(last_pl));
        end
        last_pl = {rsp_sum, rsp_carry, rsp_zero, rsp_error};
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_zero, rsp_error,
                ca_enable, ca_write, ca_strobe, ca_carryflag, ca_addend0, ca_addend1});
  endfunction

  initial begin
    int n0, n;
    logic seen;
    aresetn = 1'b0;
    req_valid = '0; req_addend0 = '0; req_addend1 = '0; req_carry = '0;

    // Reset state, with requests pending to show nothing is accepted in reset.
    req_valid = '1;
    repeat (3) @(negedge aclk);
    check("reset_outputs", all_outs(), 64'd0);
    req_valid = '0;
    @(negedge aclk);
    aresetn = 1'b1;

    // Single request, then overflow / zero cases.
    sync(); issue(0, 8'h3C, 8'h05, 1'b0); wait_idle(60);
    sync(); issue(2, 8'hFF, 8'h01, 1'b0); wait_idle(60);
    sync(); issue(2, 8'h7F, 8'h80, 1'b1); wait_idle(60);

    // Fairness: everyone held high for several grants.
    sync();
    hold_all = 1'b1;
    n0 = n_grants;
    for (int i = 0; i < NUM_REQ; i++) issue_rand(i);
    n = 0;
    while (n_grants < n0 + 5 && n < 200) begin sync(); n++; end
    check("fairness_grants", 64'(n_grants >= n0 + 5), 64'd1);
    hold_all = 1'b0;
    wait_idle(200);

    // Wrap and skip: after 3 is served, 1 and 3 valid -> 1 then 3.
    sync(); issue_rand(3); wait_idle(60);
    sync(); issue_rand(1); issue_rand(3); wait_idle(120);
    // A dropped request is skipped: 2 busy, 3 and 0 wait, 3 withdraws.
    sync(); issue_rand(2);
    repeat (3) sync();
    issue_rand(3); issue_rand(0);
    repeat (2) sync();
    req_valid[3] = 1'b0;
    wait_idle(120);

    // Randomized traffic with occasional withdrawals.
    for (int t = 0; t < 400; t++) begin
      sync();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 20) issue_rand(i);
        else if (req_valid[i] && $urandom_range(0, 99) < 3) req_valid[i] = 1'b0;
      end
    end
    wait_idle(300);

    // Adder never starts: error response, then a normal request still works.
    stuck = 1'b1;
    sync(); issue_rand(1); wait_idle(80);
    stuck = 1'b0;
    sync(); issue_rand(1); wait_idle(60);

    // Reset while the adder is running.
    sync(); issue(2, 8'h55, 8'h11, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge aclk);
      if (ca_enable && !ca_ready) seen = 1'b1;
    end
    check("reached_run", 64'(seen), 64'd1);
    @(posedge aclk); #3;
    req_valid[1] = 1'b1;
    aresetn = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    exp_q.delete();
    rr_last = NUM_REQ - 1;
    repeat (2) @(negedge aclk);
    check("reset_held_outputs", all_outs(), 64'd0);
    req_valid = '0;
    aresetn = 1'b1;
    sync(); issue(0, 8'h10, 8'h20, 1'b0); wait_idle(60);

    repeat (5) sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
